fifo_store: RTL and testbench

//   Storage and pointer control for the register-based FIFO. Holds depth words of

---
 rtl/fifo_store.sv | 106 ++++++++++
 tb/tb_fifo_store.sv | 130 +++++++++++++
 2 files changed

// File: rtl/fifo_store.sv
// fifo_store: storage and pointer control for a register-based, show-ahead FIFO.
// Word i of the storage array is driven on mem_nm_o[i*BITS +: BITS]. The
// downstream mux uses rd_ptr_o to select the head word, so the head is valid
// whenever the FIFO is not empty.
//
// Ports:
//   clk_i     clock; all state updates happen on the rising edge
//   rst_i     synchronous reset, active-high; clears pointers, count, storage
//             and the sticky error flags
//   wr_en_i   write request; din_i is stored if the write is accepted
//   din_i     write data
//   rd_en_i   read request; pops the head entry if the read is accepted
//   mem_nm_o  flattened storage array (DEPTH words), feeds mux in_nm
//   rd_ptr_o  head index, feeds mux ctrl
//   count_o   occupancy, 0..DEPTH
//   full_o    count == DEPTH
//   empty_o   count == 0
//   ovf_o     sticky: a write was rejected
//   udf_o     sticky: a read was rejected
module fifo_store #(
  parameter int BITS  = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_en_i,
  input  logic [BITS-1:0]            din_i,
  input  logic                       rd_en_i,
  output logic [DEPTH*BITS-1:0]      mem_nm_o,
  output logic [$clog2(DEPTH)-1:0]   rd_ptr_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic                       ovf_o,
  output logic                       udf_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0][BITS-1:0] mem_q;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       ovf_q, ovf_d, udf_q, udf_d;
  logic                       full, empty, wr_acc, rd_acc;

  // Flags are decoded straight from count so they line up with it.
  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);

  // A simultaneous read frees a slot, so a write is accepted even when full.
  // When empty there is no fall-through: the read is rejected.
  assign wr_acc = wr_en_i & (~full | rd_en_i);
  assign rd_acc = rd_en_i & ~empty;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q | (wr_en_i & ~wr_acc);
    udf_d    = udf_q | (rd_en_i & ~rd_acc);
    if (wr_acc)
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    if (rd_acc)
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // One register per entry; popped entries keep their contents.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    always_ff @(posedge clk_i) begin
      if (rst_i)
        mem_q[i] <= '0;
      else if (wr_acc && (wr_ptr_q == PW'(i)))
        mem_q[i] <= din_i;
    end
  end

  assign mem_nm_o = mem_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
  assign full_o   = full;
  assign empty_o  = empty;
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;
endmodule

// File: tb/tb_fifo_store.sv
module tb_fifo_store;
  logic        clk = 1'b0;
  logic        rst, wr_en, rd_en;
  logic [7:0]  din;
  logic [23:0] mem_nm;
  logic [1:0]  rd_ptr;
  logic [1:0]  count;
  logic        full, empty, ovf, udf;
  logic [7:0]  out_n;
  int          errs = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  fifo_store #(.BITS(8), .DEPTH(3)) dut (
    .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .din_i(din), .rd_en_i(rd_en),
    .mem_nm_o(mem_nm), .rd_ptr_o(rd_ptr), .count_o(count), .full_o(full),
    .empty_o(empty), .ovf_o(ovf), .udf_o(udf)
  );

  // Downstream mux (muxnm) model.
  assign out_n = mem_nm[rd_ptr*8 +: 8];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Apply inputs for one clock, sample 1 time unit after the edge.
  task automatic cyc(input logic r, input logic w, input logic rd, input logic [7:0] d);
    rst = r; wr_en = w; rd_en = rd; din = d;
    @(posedge clk); #1;
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    // 1. reset
    cyc(1, 0, 0, 8'h00);
    cyc(1, 1, 1, 8'hFF);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full",  full, 0);
    chk("rst_rdptr", rd_ptr, 0);
    chk("rst_mem",   mem_nm, 24'h0);
    chk("rst_ovf",   ovf, 0);
    chk("rst_udf",   udf, 0);

    // 2. fill, then overflow
    cyc(0, 1, 0, 8'h11);
    chk("w1_head",  out_n, 8'h11);
    chk("w1_empty", empty, 0);
    cyc(0, 1, 0, 8'h22);
    cyc(0, 1, 0, 8'h33);
    chk("fill_full",  full, 1);
    chk("fill_count", count, 3);
    cyc(0, 1, 0, 8'h44);
    chk("ovf_flag",  ovf, 1);
    chk("ovf_mem",   mem_nm, 24'h332211);
    chk("ovf_count", count, 3);

    // 3. drain, then underflow
    chk("rd0_head", out_n, 8'h11);
    cyc(0, 0, 1, 8'h00);
    chk("rd1_head", out_n, 8'h22);
    cyc(0, 0, 1, 8'h00);
    chk("rd2_head", out_n, 8'h33);
    cyc(0, 0, 1, 8'h00);
    chk("drain_empty", empty, 1);
    chk("drain_rdptr", rd_ptr, 0);
    chk("drain_mem",   mem_nm, 24'h332211);
    cyc(0, 0, 1, 8'h00);
    chk("udf_flag",  udf, 1);
    chk("udf_rdptr", rd_ptr, 0);
    chk("udf_count", count, 0);
    chk("ovf_sticky", ovf, 1);

    // 4. wrap with single write/read pairs
    begin
      logic [1:0] exp_ptr [5];
      logic [7:0] vals    [5];
      exp_ptr = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
      vals    = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      for (int k = 0; k < 5; k++) begin
        cyc(0, 1, 0, vals[k]);
        chk($sformatf("wrap%0d_ptr", k),  rd_ptr, exp_ptr[k]);
        chk($sformatf("wrap%0d_head", k), out_n, vals[k]);
        cyc(0, 0, 1, 8'h00);
        chk($sformatf("wrap%0d_empty", k), empty, 1);
      end
    end

    // 5. simultaneous write/read while full
    cyc(0, 1, 0, 8'hB1);
    cyc(0, 1, 0, 8'hB2);
    cyc(0, 1, 0, 8'hB3);
    chk("f5_full", full, 1);
    chk("f5_head", out_n, 8'hB1);
    cyc(0, 1, 1, 8'hAA);
    chk("f5_count", count, 3);
    chk("f5_pop",   out_n, 8'hB2);
    cyc(0, 0, 1, 8'h00);
    chk("f5_rd1", out_n, 8'hB3);
    cyc(0, 0, 1, 8'h00);
    chk("f5_rd2", out_n, 8'hAA);
    chk("f5_cnt1", count, 1);

    // 6. simultaneous write/read while empty, then reset mid-operation
    cyc(1, 0, 0, 8'h00);
    chk("r6_udf", udf, 0);
    chk("r6_ovf", ovf, 0);
    cyc(0, 1, 1, 8'h5A);
    chk("e6_count", count, 1);
    chk("e6_udf",   udf, 1);
    chk("e6_head",  out_n, 8'h5A);
    chk("e6_rdptr", rd_ptr, 0);
    cyc(0, 1, 0, 8'h6B);
    chk("e6_count2", count, 2);
    cyc(1, 1, 0, 8'h77);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_empty", empty, 1);
    chk("mid_rst_mem",   mem_nm, 24'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
